// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package imem_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;
  // Width of the starvation counter; holds MAX_WAIT values 1..15.
  localparam int WAIT_W     = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PROG  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/imem_arbiter_starve_counter.sv
// Saturating loader starvation timer. It is a down-counter that is loaded with
// MAX_WAIT on clear and steps toward zero on each denied loader cycle.
// Zero is the terminal count and is reported as at_max.
module starve_counter
  import imem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [WAIT_W-1:0] remain;

  // Reload on reset or clear, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      remain <= WAIT_W'(MAX_WAIT);
    end else if (inc && (remain != '0)) begin
      remain <= remain - 1'b1;
    end
  end

  assign at_max = (remain == '0);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter shared by fetch (priority) and the
// program loader, with a starvation guarantee and an exclusive program mode.
//
//   state | meaning
//   ------+-------------------------------------------------
//   RUN   | shared: starved loader > fetch > loader
//   PROG  | loader exclusive, fetch always stalled
//   DRAIN | one idle cycle, prog_done pulse, back to RUN
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_stall,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  input  logic              prog_mode,
  output logic              prog_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, state_nxt;
  logic       at_max;
  logic       f_grant;
  logic       l_grant;
  logic       prog_rules;
  logic       wait_clr;
  logic       wait_inc;
  logic       rvalid_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (prog_mode)  state_nxt = ST_PROG;
      ST_PROG:  if (!prog_mode) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Grant decode. The RUN->PROG transition cycle already uses loader-exclusive
  // rules, so a pending starvation grant and a prog_mode rise both end in a
  // loader grant.
  always_comb begin
    f_grant    = 1'b0;
    l_grant    = 1'b0;
    prog_rules = 1'b0;
    prog_done  = 1'b0;
    if (rst) begin
      case (state)
        ST_RUN: begin
          if (prog_mode) begin
            prog_rules = 1'b1;
            l_grant    = l_req;
          end else if (l_req && at_max) begin
            l_grant = 1'b1;
          end else if (f_req) begin
            f_grant = 1'b1;
          end else begin
            l_grant = l_req;
          end
        end
        ST_PROG: begin
          prog_rules = 1'b1;
          l_grant    = l_req;
        end
        ST_DRAIN: prog_done = 1'b1;
        default: ;
      endcase
    end
  end

  assign wait_inc = l_req & ~l_grant & ~prog_rules;
  assign wait_clr = prog_rules | ~l_req | l_grant;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .clr    (wait_clr),
    .inc    (wait_inc),
    .at_max (at_max)
  );

  assign mem_en    = f_grant | l_grant;
  assign mem_we    = l_grant;
  assign mem_addr  = l_grant ? l_addr : (f_grant ? f_addr : '0);
  assign mem_wdata = l_grant ? l_wdata : '0;
  assign l_ack     = l_grant;
  assign f_stall   = rst & f_req & ~f_grant;

  // Read-data valid follows a fetch grant by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= f_grant;
    end
  end

  // Outputs are forced low while reset is held, including the registered valid.
  assign f_rvalid = rst & rvalid_q;
  assign f_rdata  = rst ? mem_rdata : '0;

endmodule
